// File: rtl/clock_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Optional tick counter is enabled with CLKDIV_TICK_COUNT_EN.
package clock_div_pkg;

  localparam int CLKDIV_WIDTH_DEFAULT = 17;
  localparam int CLKDIV_TICKCNT_W     = 16;

  typedef logic [CLKDIV_WIDTH_DEFAULT-1:0] div_t;

endpackage

// File: rtl/prog_clock_div_if.sv
// Control/status bundle of prog_clock_div.
// tick_count exists only when CLKDIV_TICK_COUNT_EN is defined.
interface prog_clock_div_if
  import clock_div_pkg::*;
#(
  parameter int WIDTH = CLKDIV_WIDTH_DEFAULT
);

  logic             enable;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             div_clock;
  logic             tick;
  logic [WIDTH-1:0] active_div;
  logic             pending;
  logic             load_err;
`ifdef CLKDIV_TICK_COUNT_EN
  logic [CLKDIV_TICKCNT_W-1:0] tick_count;

  modport master (
    output enable, div_load, div_value,
    input  div_clock, tick, active_div,
    input  pending, load_err, tick_count
  );

  modport slave (
    input  enable, div_load, div_value,
    output div_clock, tick, active_div,
    output pending, load_err, tick_count
  );
`else
  modport master (
    output enable, div_load, div_value,
    input  div_clock, tick, active_div,
    input  pending, load_err
  );

  modport slave (
    input  enable, div_load, div_value,
    output div_clock, tick, active_div,
    output pending, load_err
  );
`endif

endinterface

// File: rtl/clkdiv_load_ctrl.sv
// Divisor load/apply control: holds the pending divisor and decides
// when it replaces the active one (period boundary or while disabled).
module clkdiv_load_ctrl
  import clock_div_pkg::*;
#(
  parameter int WIDTH       = CLKDIV_WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic             at_end,
  output logic             apply,
  output logic [WIDTH-1:0] div_nxt,
  output logic [WIDTH-1:0] active_div,
  output logic             pending,
  output logic             load_err
);

  logic [WIDTH-1:0] pending_div;
  logic [WIDTH-1:0] cand;
  logic             load_ok;
  logic             load_bad;
  logic             want;

  // A load landing on the wrap cycle is folded straight into the apply.
  always_comb begin
    load_ok  = div_load && (div_value != '0);
    load_bad = div_load && (div_value == '0);
    want     = pending || load_ok;
    cand     = load_ok ? div_value : pending_div;
    apply    = want && (at_end || !enable);
    div_nxt  = apply ? cand : active_div;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_div  <= WIDTH'(DEFAULT_DIV);
      pending_div <= '0;
      pending     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= load_bad;
      if (apply) begin
        active_div <= cand;
        pending    <= 1'b0;
      end else if (load_ok) begin
        pending_div <= div_value;
        pending     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_clock_div.sv
// Synchronous programmable divider: tick strobe and square div_clock.
// Define CLKDIV_TICK_COUNT_EN to add the 16-bit tick_count output.
module prog_clock_div
  import clock_div_pkg::*;
#(
  parameter int WIDTH       = CLKDIV_WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input logic             clock,
  input logic             reset,
  prog_clock_div_if.slave bus
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] active_div;
  logic [WIDTH:0]   half_nxt;
  logic             at_end;
  logic             apply;
  logic             tick_q;
  logic             dclk_q;

  clkdiv_load_ctrl #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_load (
    .clock      (clock),
    .reset      (reset),
    .enable     (bus.enable),
    .div_load   (bus.div_load),
    .div_value  (bus.div_value),
    .at_end     (at_end),
    .apply      (apply),
    .div_nxt    (div_nxt),
    .active_div (active_div),
    .pending    (bus.pending),
    .load_err   (bus.load_err)
  );

  // div_clock tracks the count it is registered with, so it is
  // derived from the next count and the next divisor.
  always_comb begin
    at_end = (count == active_div - WIDTH'(1));
    if (apply)
      cnt_nxt = '0;
    else if (bus.enable && at_end)
      cnt_nxt = '0;
    else if (bus.enable)
      cnt_nxt = count + WIDTH'(1);
    else
      cnt_nxt = count;
    half_nxt = ({1'b0, div_nxt} + (WIDTH+1)'(1)) >> 1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      tick_q <= 1'b0;
      dclk_q <= 1'b0;
    end else begin
      count  <= cnt_nxt;
      tick_q <= bus.enable && at_end;
      dclk_q <= ({1'b0, cnt_nxt} >= half_nxt);
    end
  end

  assign bus.tick       = tick_q;
  assign bus.div_clock  = dclk_q;
  assign bus.active_div = active_div;

`ifdef CLKDIV_TICK_COUNT_EN
  logic [CLKDIV_TICKCNT_W-1:0] tick_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)
      tick_cnt_q <= '0;
    else if (tick_q)
      tick_cnt_q <= tick_cnt_q + CLKDIV_TICKCNT_W'(1);
  end

  assign bus.tick_count = tick_cnt_q;
`endif

endmodule

// File: tb/tb_prog_clock_div.sv
// Scoreboard bench for prog_clock_div: directed cycles push expected
// outputs, a monitor pops and compares one cycle later.
module tb_prog_clock_div;
  import clock_div_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  prog_clock_div_if #(.WIDTH(CLKDIV_WIDTH_DEFAULT)) bus();

  prog_clock_div #(
    .WIDTH       (CLKDIV_WIDTH_DEFAULT),
    .DEFAULT_DIV (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [20:0] exp_q[$];
  string       name_q[$];

  // {tick, div_clock, active_div, pending, load_err}
  initial begin
    logic [20:0] e;
    logic [20:0] g;
    string       n;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        g = {bus.tick, bus.div_clock, bus.active_div,
             bus.pending, bus.load_err};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL %s: got t=%0b d=%0b a=%0d p=%0b e=%0b want t=%0b d=%0b a=%0d p=%0b e=%0b",
                   n, g[20], g[19], g[18:2], g[1], g[0],
                   e[20], e[19], e[18:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic cyc(
    input string       nm,
    input logic        rs,
    input logic        en,
    input logic        ld,
    input logic [16:0] val,
    input logic        et,
    input logic        ed,
    input logic [16:0] ea,
    input logic        ep,
    input logic        ee
  );
    @(negedge clock);
    reset         = rs;
    bus.enable    = en;
    bus.div_load  = ld;
    bus.div_value = val;
    exp_q.push_back({et, ed, ea, ep, ee});
    name_q.push_back(nm);
  endtask

  // Free-running enabled cycles; tk/dc are per-cycle expected bits.
  task automatic wave(
    input string       nm,
    input string       tk,
    input string       dc,
    input logic [16:0] act
  );
    for (int i = 0; i < tk.len(); i++)
      cyc($sformatf("%s[%0d]", nm, i), 1'b0, 1'b1, 1'b0, 17'd0,
          tk.substr(i, i) == "1", dc.substr(i, i) == "1",
          act, 1'b0, 1'b0);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_value = '0;

    cyc("rst0", 1, 0, 0, 0, 0, 0, 2, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 2, 0, 0);
    wave("n2", "0101", "1010", 2);

    cyc("ld4",   0, 1, 1, 4, 0, 1, 2, 1, 0);
    cyc("ap4",   0, 1, 0, 0, 1, 0, 4, 0, 0);
    cyc("n4a",   0, 1, 0, 0, 0, 0, 4, 0, 0);
    cyc("ld5",   0, 1, 1, 5, 0, 1, 4, 1, 0);
    cyc("pend5", 0, 1, 0, 0, 0, 1, 4, 1, 0);
    cyc("ap5",   0, 1, 0, 0, 1, 0, 5, 0, 0);
    wave("n5", "0000100001", "0011000110", 5);

    cyc("ld3",  0, 1, 1, 3, 0, 0, 5, 1, 0);
    cyc("ld7",  0, 1, 1, 7, 0, 0, 5, 1, 0);
    cyc("p7a",  0, 1, 0, 0, 0, 1, 5, 1, 0);
    cyc("p7b",  0, 1, 0, 0, 0, 1, 5, 1, 0);
    cyc("ap7",  0, 1, 0, 0, 1, 0, 7, 0, 0);
    wave("n7", "0000001", "0001110", 7);
    cyc("ld0",  0, 1, 1, 0, 0, 0, 7, 0, 1);
    cyc("eclr", 0, 1, 0, 0, 0, 0, 7, 0, 0);
    wave("n7b", "00001", "01110", 7);

    wave("n7c", "000000", "000111", 7);
    cyc("ld1w", 0, 1, 1, 1, 1, 0, 1, 0, 0);
    wave("n1", "11111", "00000", 1);

    cyc("ld6w", 0, 1, 1, 6, 1, 0, 6, 0, 0);
    wave("n6", "00", "00", 6);
    for (int i = 0; i < 10; i++)
      cyc("frz", 0, 0, 0, 0, 0, 0, 6, 0, 0);
    wave("resume", "0001", "1110", 6);

    cyc("ld3b",   0, 1, 1, 3, 0, 0, 6, 1, 0);
    cyc("rstmid", 1, 1, 1, 9, 0, 0, 2, 0, 0);
    wave("postrst", "0101", "1010", 2);

`ifdef CLKDIV_TICK_COUNT_EN
    begin
      int nt;
      @(negedge clock);
      reset        = 1'b1;
      bus.enable   = 1'b1;
      bus.div_load = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (bus.tick_count !== 16'd0) begin
        n_bad++;
        $display("FAIL tcnt_rst: got %0d want 0", bus.tick_count);
      end
      reset         = 1'b0;
      bus.div_load  = 1'b1;
      bus.div_value = 17'd1;
      @(negedge clock);
      bus.div_load = 1'b0;
      nt = 0;
      for (int i = 0; i < 80000 && nt < 70000; i++) begin
        @(negedge clock);
        if (bus.tick) nt++;
        if (nt == 70000) bus.enable = 1'b0;
      end
      bus.enable = 1'b0;
      @(negedge clock);
      @(negedge clock);
      n_cmp++;
      if (nt != 70000 || bus.tick_count !== 16'd4464) begin
        n_bad++;
        $display("FAIL tcnt_70k: got %0d after %0d ticks want 4464",
                 bus.tick_count, nt);
      end
    end
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
